// File: rtl/dft_probe_sequencer.sv
// ---------------------------------------------------------------------------
// dft_probe_sequencer
//
// Time-multiplexes a bank of DFT probe cells onto one shared observation
// return. A round-robin arbiter picks one requesting probe, raises its
// one-hot test-enable, waits SETTLE cycles, samples the synchronised return
// for DWELL cycles and reports the majority vote. A single GUARD cycle with
// all enables low separates consecutive grants (break-before-make).
//
// Optional build macro: DFT_PROBE_COUNT_EN
//   When defined, adds ones_cnt: raw ones count of the last completed grant
//   (updated with done, 0 on abort, 0 on reset).
//
// Ports:
//   clk       in   block clock
//   rst       in   synchronous active-high reset
//   req       in   [NPROBE] per-probe level request, sampled only in IDLE
//   abort     in   ends the current grant (honoured in SETTLE/DWELL only)
//   obs_i     in   shared return, asynchronous, two-flop synchronised
//   ten       out  [NPROBE] one-hot test-enable, all-zero when idle
//   busy      out  high from grant until return to IDLE
//   grant_id  out  [IDW] granted / last-granted probe index
//   done      out  one-cycle pulse, result/aborted valid
//   result    out  majority of dwell samples, held until next done
//   aborted   out  grant ended via abort, held until next done
//   ones_cnt  out  [4] (DFT_PROBE_COUNT_EN only) raw ones count
// ---------------------------------------------------------------------------
module dft_probe_sequencer #(
    parameter int NPROBE = 4,
    parameter int SETTLE = 3,
    parameter int DWELL  = 7,
    parameter int IDW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NPROBE-1:0] req,
    input  logic              abort,
    input  logic              obs_i,
    output logic [NPROBE-1:0] ten,
    output logic              busy,
    output logic [IDW-1:0]    grant_id,
    output logic              done,
    output logic              result,
    output logic              aborted
`ifdef DFT_PROBE_COUNT_EN
    ,
    output logic [3:0]        ones_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DWELL  = 2'd2,
        S_GUARD  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        ones_q, ones_d;
    logic              abrt_q, abrt_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [NPROBE-1:0] ten_q, ten_d;
    logic              busy_q, busy_d;
    logic [IDW-1:0]    gid_q, gid_d;
    logic              done_q, done_d;
    logic              res_q, res_d;
    logic              abo_q, abo_d;
`ifdef DFT_PROBE_COUNT_EN
    logic [3:0]        ocnt_q, ocnt_d;
`endif

    logic              obs_s1_q, obs_s2_q;

    // Round-robin pick: first requester at or after the pointer, wrapping.
    logic              arb_hit;
    logic [IDW-1:0]    arb_idx;
    always_comb begin
        int idx;
        arb_hit = 1'b0;
        arb_idx = '0;
        idx     = 0;
        for (int i = 0; i < NPROBE; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NPROBE) idx = idx - NPROBE;
            if (!arb_hit && req[idx]) begin
                arb_hit = 1'b1;
                arb_idx = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ones_d  = ones_q;
        abrt_d  = abrt_q;
        ptr_d   = ptr_q;
        ten_d   = ten_q;
        busy_d  = busy_q;
        gid_d   = gid_q;
        done_d  = 1'b0;
        res_d   = res_q;
        abo_d   = abo_q;
`ifdef DFT_PROBE_COUNT_EN
        ocnt_d  = ocnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_hit) begin
                    state_d = S_SETTLE;
                    ten_d   = NPROBE'(1) << arb_idx;
                    gid_d   = arb_idx;
                    busy_d  = 1'b1;
                    ptr_d   = (int'(arb_idx) == NPROBE - 1) ? '0 : arb_idx + IDW'(1);
                    cnt_d   = '0;
                    ones_d  = '0;
                    abrt_d  = 1'b0;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_GUARD;
                    ten_d   = '0;
                    abrt_d  = 1'b1;
                end else if (cnt_q == 4'(SETTLE - 1)) begin
                    state_d = S_DWELL;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            S_DWELL: begin
                // abort outranks the final sample
                if (abort) begin
                    state_d = S_GUARD;
                    ten_d   = '0;
                    abrt_d  = 1'b1;
                end else begin
                    ones_d = ones_q + {3'b000, obs_s2_q};
                    if (cnt_q == 4'(DWELL - 1)) begin
                        state_d = S_GUARD;
                        ten_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            S_GUARD: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                cnt_d   = '0;
                res_d   = !abrt_q && (ones_q > 4'(DWELL / 2));
                abo_d   = abrt_q;
`ifdef DFT_PROBE_COUNT_EN
                ocnt_d  = abrt_q ? 4'd0 : ones_q;
`endif
            end
            default: begin
                state_d = S_IDLE;
                ten_d   = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ones_q   <= '0;
            abrt_q   <= 1'b0;
            ptr_q    <= '0;
            ten_q    <= '0;
            busy_q   <= 1'b0;
            gid_q    <= '0;
            done_q   <= 1'b0;
            res_q    <= 1'b0;
            abo_q    <= 1'b0;
            obs_s1_q <= 1'b0;
            obs_s2_q <= 1'b0;
`ifdef DFT_PROBE_COUNT_EN
            ocnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ones_q   <= ones_d;
            abrt_q   <= abrt_d;
            ptr_q    <= ptr_d;
            ten_q    <= ten_d;
            busy_q   <= busy_d;
            gid_q    <= gid_d;
            done_q   <= done_d;
            res_q    <= res_d;
            abo_q    <= abo_d;
            obs_s1_q <= obs_i;
            obs_s2_q <= obs_s1_q;
`ifdef DFT_PROBE_COUNT_EN
            ocnt_q   <= ocnt_d;
`endif
        end
    end

    assign ten      = ten_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;
    assign done     = done_q;
    assign result   = res_q;
    assign aborted  = abo_q;
`ifdef DFT_PROBE_COUNT_EN
    assign ones_cnt = ocnt_q;
`endif

endmodule

// File: tb/tb_dft_probe_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dft_probe_sequencer
//
// Directed bench for dft_probe_sequencer with default parameters
// (NPROBE=4, SETTLE=3, DWELL=7). Expected values are hand-computed.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_dft_probe_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       abort = 1'b0;
    logic       obs_i = 1'b0;
    logic [3:0] ten;
    logic       busy;
    logic [1:0] grant_id;
    logic       done;
    logic       result;
    logic       aborted;
`ifdef DFT_PROBE_COUNT_EN
    logic [3:0] ones_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit multi_hot = 1'b0;

    dft_probe_sequencer #(.NPROBE(4), .SETTLE(3), .DWELL(7), .IDW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .abort    (abort),
        .obs_i    (obs_i),
        .ten      (ten),
        .busy     (busy),
        .grant_id (grant_id),
        .done     (done),
        .result   (result),
        .aborted  (aborted)
`ifdef DFT_PROBE_COUNT_EN
        ,
        .ones_cnt (ones_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if ($countones(ten) > 1) multi_hot = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 64) begin tick(); n++; end
        chk(tag, done, 1);
    endtask

    // Grant probe 1, then drive obs so the seven dwell samples equal pat
    // (MSB first). Samples lag obs_i by two cycles through the synchroniser.
    task automatic run_pat(input logic [6:0] pat, input logic exp_res, input logic [3:0] exp_ones);
        req = 4'b0010;
        tick();
        chk("pat_ten", ten, 4'b0010);
        req = 4'b0000;
        for (int j = 0; j < 7; j++) begin
            tick();
            obs_i = pat[6-j];
        end
        tick();
        obs_i = 1'b0;
        wait_done("pat_done");
        chk("pat_result", result, exp_res);
        chk("pat_aborted", aborted, 0);
`ifdef DFT_PROBE_COUNT_EN
        chk("pat_ones_cnt", ones_cnt, exp_ones);
`else
        if (exp_ones > 4'd3) chk("pat_vote", result, 1);
        else                 chk("pat_vote", result, 0);
`endif
    endtask

    initial begin
        int n;
        int rise, last_high;
        bit saw_done;

        // ---- reset state ----
        tick(); tick();
        chk("rst_ten", ten, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_aborted", aborted, 0);

        // ---- single grant, obs=1 ----
        rst = 1'b0;
        req = 4'b0100;
        obs_i = 1'b1;
        tick();
        chk("t1_ten", ten, 4'b0100);
        chk("t1_gid", grant_id, 2);
        chk("t1_busy", busy, 1);
        req = 4'b0000;
        n = 1;
        tick();
        while (ten == 4'b0100 && n < 50) begin n++; tick(); end
        chk("t1_ten_len", n, 10);
        chk("t1_guard_ten", ten, 0);
        chk("t1_guard_busy", busy, 1);
        chk("t1_guard_done", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_result", result, 1);
        chk("t1_aborted", aborted, 0);
        chk("t1_gid_hold", grant_id, 2);
        chk("t1_idle_busy", busy, 0);
`ifdef DFT_PROBE_COUNT_EN
        chk("t1_ones_cnt", ones_cnt, 7);
`endif
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_result_hold", result, 1);

        // ---- round robin over all four, obs=0 ----
        obs_i = 1'b0;
        do_reset();
        req = 4'b1111;
        last_high = 0;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (ten == 0 && n < 64) begin tick(); n++; end
            rise = cyc;
            chk("t2_gid", grant_id, g % 4);
            chk("t2_ten", ten, 4'b0001 << (g % 4));
            if (g > 0) chk("t2_gap", rise - last_high - 1, 2);
            while (ten != 0 && n < 64) begin tick(); n++; end
            last_high = cyc - 1;
            wait_done("t2_done");
            chk("t2_result", result, 0);
            if (g == 4) req = 4'b0000;
        end
        tick();
        chk("t2_idle_after", ten, 0);

        // ---- majority vote patterns on probe 1 ----
        do_reset();
        run_pat(7'b1101000, 1'b0, 4'd3);
        run_pat(7'b1101100, 1'b1, 4'd4);

        // ---- abort on 2nd dwell cycle of probe 3 ----
        req = 4'b1000;
        tick();
        chk("t4_gid", grant_id, 3);
        req = 4'b0000;
        tick(); tick(); tick(); tick();
        chk("t4_ten_pre", ten, 4'b1000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_ten_off", ten, 0);
        chk("t4_busy", busy, 1);
        chk("t4_nodone", done, 0);
        tick();
        chk("t4_done", done, 1);
        chk("t4_aborted", aborted, 1);
        chk("t4_result", result, 0);
`ifdef DFT_PROBE_COUNT_EN
        chk("t4_ones_cnt", ones_cnt, 0);
`endif
        // pointer wrapped to 0; abort in IDLE is ignored
        req = 4'b1111;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        req = 4'b0000;
        chk("t4_ptr0_gid", grant_id, 0);
        chk("t4_ptr0_ten", ten, 4'b0001);
        wait_done("t4b_done");
        chk("t4b_aborted", aborted, 0);

        // ---- reset on 5th cycle of a grant ----
        req = 4'b0100;
        tick();
        chk("t5_gid", grant_id, 2);
        req = 4'b0000;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_ten", ten, 0);
        chk("t5_busy", busy, 0);
        chk("t5_gid0", grant_id, 0);
        saw_done = done;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        chk("t5_nodone", saw_done, 0);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        chk("t5_regrant_gid", grant_id, 1);
        chk("t5_regrant_ten", ten, 4'b0010);

        chk("onehot", multi_hot, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
